// File: rtl/uio_bus_arbiter_if.sv
// uio_bus_arbiter_if: request/ack handshakes of the uio bus users plus the pad-side bus signals.
interface uio_bus_arbiter_if;
    logic       ena;
    logic [1:0] wr_req;
    logic [7:0] wr_data0;
    logic [7:0] wr_data1;
    logic [1:0] wr_ack;
    logic       rd_req;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       busy;

    // Arbiter side: samples requests and the pad input, owns acks and the pad drivers.
    modport slave (
        input  ena, wr_req, wr_data0, wr_data1, rd_req, uio_in,
        output wr_ack, rd_ack, rd_data, uio_out, uio_oe, busy
    );

    // Requester/pad side.
    modport master (
        output ena, wr_req, wr_data0, wr_data1, rd_req, uio_in,
        input  wr_ack, rd_ack, rd_data, uio_out, uio_oe, busy
    );
endinterface

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the bidirectional uio pad bus. Grants two writers and one
// reader, inserts turnaround cycles on every direction change and drives uio_oe/uio_out from
// registers only.
module uio_bus_arbiter #(
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    uio_bus_arbiter_if.slave bus
);
    localparam int unsigned MaxCycles = (TURN_CYCLES > HOLD_CYCLES) ? TURN_CYCLES : HOLD_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] TurnLast = CntW'(TURN_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);

    localparam logic [1:0] SrcWr0 = 2'd0;
    localparam logic [1:0] SrcWr1 = 2'd1;
    localparam logic [1:0] SrcRd  = 2'd2;

    typedef enum logic [1:0] {StIdle, StTurn, StDrive, StSample} state_e;

    state_e          state;
    logic [CntW-1:0] cnt;       // cycles left in TURN/DRIVE after the current one
    logic            last_out;  // 1 when the last completed transaction drove the bus
    logic [1:0]      rr_start;  // first source examined by the next round-robin search
    logic [1:0]      gnt;
    logic [7:0]      gnt_data;

    logic [2:0] req_vec;
    logic [5:0] order;
    logic [1:0] pick;
    logic       pick_vld;
    logic       launch;
    logic [1:0] launch_src;
    logic [7:0] launch_data;

    function automatic logic [1:0] ack_of(input logic [1:0] src);
        return {src == SrcWr1, src == SrcWr0};
    endfunction

    assign bus.busy = (state != StIdle);

    // Round-robin search over {wr0, wr1, rd} beginning at rr_start.
    always_comb begin
        req_vec  = {bus.rd_req, bus.wr_req};
        pick     = SrcWr0;
        pick_vld = 1'b0;
        unique case (rr_start)
            2'd1:    order = {SrcWr0, SrcRd, SrcWr1};
            2'd2:    order = {SrcWr1, SrcWr0, SrcRd};
            default: order = {SrcRd, SrcWr1, SrcWr0};
        endcase
        for (int k = 0; k < 3; k++) begin
            if (!pick_vld && req_vec[order[2*k +: 2]]) begin
                pick     = order[2*k +: 2];
                pick_vld = 1'b1;
            end
        end
    end

    // Decide when the data phase (DRIVE or SAMPLE) starts: straight from IDLE when the direction
    // is unchanged, otherwise at the end of TURN.
    always_comb begin
        launch      = 1'b0;
        launch_src  = gnt;
        launch_data = gnt_data;
        if (state == StIdle) begin
            launch      = bus.ena && pick_vld && ((pick != SrcRd) == last_out);
            launch_src  = pick;
            launch_data = (pick == SrcWr1) ? bus.wr_data1 : bus.wr_data0;
        end else if (state == StTurn) begin
            launch = (cnt == '0);
        end
    end

    // Transaction FSM with registered pad drivers, acks and read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= StIdle;
            cnt         <= '0;
            last_out    <= 1'b0;
            rr_start    <= SrcWr0;
            gnt         <= SrcWr0;
            gnt_data    <= '0;
            bus.uio_oe  <= '0;
            bus.uio_out <= '0;
            bus.wr_ack  <= '0;
            bus.rd_ack  <= 1'b0;
            bus.rd_data <= '0;
        end else begin
            bus.wr_ack <= '0;
            bus.rd_ack <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.ena && pick_vld) begin
                        gnt      <= pick;
                        gnt_data <= launch_data;
                        rr_start <= (pick == SrcRd) ? SrcWr0 : pick + 2'd1;
                        if (!launch) begin
                            state      <= StTurn;
                            cnt        <= TurnLast;
                            bus.uio_oe <= '0;
                        end
                    end
                end
                StTurn: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StDrive: begin
                    if (cnt == '0) begin
                        state    <= StIdle;
                        last_out <= 1'b1;
                    end else begin
                        cnt <= cnt - CntW'(1);
                        // Ack rides along with the final DRIVE cycle.
                        if (cnt == CntW'(1)) begin
                            bus.wr_ack <= ack_of(gnt);
                        end
                    end
                end
                StSample: begin
                    bus.rd_data <= bus.uio_in;
                    bus.rd_ack  <= 1'b1;
                    last_out    <= 1'b0;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase

            if (launch) begin
                if (launch_src != SrcRd) begin
                    state       <= StDrive;
                    cnt         <= HoldLast;
                    bus.uio_oe  <= 8'hFF;
                    bus.uio_out <= launch_data;
                    if (HOLD_CYCLES == 1) begin
                        bus.wr_ack <= ack_of(launch_src);
                    end
                end else begin
                    state      <= StSample;
                    bus.uio_oe <= 8'h00;
                end
            end
        end
    end
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter: randomized and directed stimulus against a transaction-level model of the
// arbiter; expected acks and per-cycle bus states are queued by the driver and checked by a
// separate monitor.
module tb_uio_bus_arbiter;
    localparam int TURN = 1;
    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    uio_bus_arbiter_if bus ();

    uio_bus_arbiter #(
        .TURN_CYCLES(TURN),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         src;      // 0 wr0, 1 wr1, 2 rd
        logic [7:0] data;     // uio_out at write ack, rd_data at read ack
        int         ack_cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_oe  [int];
    logic [7:0] exp_out [int];

    // Model state: who is examined first, last bus direction, last value driven on uio_out.
    int         rr_next;
    bit         last_out;
    logic [7:0] last_data;
    logic [7:0] data_m [2];
    int         next_dec;  // cycle whose opening edge takes the next grant decision

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        rr_next   = 0;
        last_out  = 1'b0;
        last_data = 8'h00;
    endtask

    function automatic int pick(input logic [2:0] s);
        int idx;
        for (int k = 0; k < 3; k++) begin
            idx = (rr_next + k) % 3;
            if (s[idx]) return idx;
        end
        return -1;
    endfunction

    // Drop all requests for one decision, then present a new request set and write data.
    task automatic start_segment(input logic [2:0] s, input logic [7:0] d0, input logic [7:0] d1);
        wait_cyc(next_dec - 1);
        bus.wr_req = 2'b00;
        bus.rd_req = 1'b0;
        next_dec++;
        wait_cyc(next_dec - 1);
        data_m[0]    = d0;
        data_m[1]    = d1;
        bus.wr_data0 = d0;
        bus.wr_data1 = d1;
        bus.wr_req   = s[1:0];
        bus.rd_req   = s[2];
    endtask

    // One grant decision with request set s held; queues what the bus and acks must show.
    task automatic do_grant(input logic [2:0] s, input bit abort,
                            output int dec, output int t, output int ack);
        int         g;
        bit         wr;
        exp_t       e;
        logic [7:0] din;
        wait_cyc(next_dec - 1);
        din        = 8'($urandom);
        bus.uio_in = din;
        g   = pick(s);
        wr  = (g != 2);
        dec = next_dec;
        t   = (wr != last_out) ? TURN : 0;
        ack = wr ? dec + t + HOLD - 1 : dec + t + 1;
        if (abort) return;
        for (int i = 0; i < t; i++) begin
            exp_oe[dec + i]  = 8'h00;
            exp_out[dec + i] = last_data;
        end
        if (wr) begin
            for (int i = 0; i < HOLD; i++) begin
                exp_oe[dec + t + i]  = 8'hFF;
                exp_out[dec + t + i] = data_m[g];
            end
            last_data = data_m[g];
            e.data    = data_m[g];
        end else begin
            exp_oe[dec + t]  = 8'h00;
            exp_out[dec + t] = last_data;
            e.data           = din;
        end
        e.src     = g;
        e.ack_cyc = ack;
        exp_q.push_back(e);
        rr_next  = (g + 1) % 3;
        last_out = wr;
        next_dec = ack + (wr ? 2 : 1);
    endtask

    task automatic run_seg(input logic [2:0] s, input int n, input logic [7:0] d0,
                           input logic [7:0] d1);
        int dec, t, ack;
        start_segment(s, d0, d1);
        repeat (n) do_grant(s, 1'b0, dec, t, ack);
    endtask

    // Monitor: per-cycle bus expectations and ack scoreboard.
    initial begin
        exp_t e;
        int   got_src;
        forever begin
            @(negedge clk);
            if (exp_oe.exists(cyc)) begin
                check("bus_oe", 32'(bus.uio_oe), 32'(exp_oe[cyc]));
                check("bus_out", 32'(bus.uio_out), 32'(exp_out[cyc]));
                check("bus_busy", 32'(bus.busy), 32'd1);
                exp_oe.delete(cyc);
                exp_out.delete(cyc);
            end
            if ((|bus.wr_ack) === 1'b1 || bus.rd_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {29'd0, bus.rd_ack, bus.wr_ack}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    case ({bus.rd_ack, bus.wr_ack})
                        3'b001:  got_src = 0;
                        3'b010:  got_src = 1;
                        3'b100:  got_src = 2;
                        default: got_src = 3;
                    endcase
                    check("ack_source", got_src, e.src);
                    check("ack_cycle", cyc, e.ack_cyc);
                    if (e.src == 2) check("rd_data", 32'(bus.rd_data), 32'(e.data));
                    else            check("wr_data_on_bus", 32'(bus.uio_out), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dec, t, ack;
        rst          = 1'b0;
        bus.ena      = 1'b1;
        bus.wr_req   = 2'b00;
        bus.rd_req   = 1'b0;
        bus.wr_data0 = 8'h00;
        bus.wr_data1 = 8'h00;
        bus.uio_in   = 8'h00;
        model_reset();

        // Reset state.
        wait_cyc(3);
        @(negedge clk);
        check("rst_oe", 32'(bus.uio_oe), 32'h00);
        check("rst_out", 32'(bus.uio_out), 32'h00);
        check("rst_wr_ack", 32'(bus.wr_ack), 32'h0);
        check("rst_rd_ack", 32'(bus.rd_ack), 32'h0);
        check("rst_rd_data", 32'(bus.rd_data), 32'h00);
        check("rst_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        next_dec = cyc + 1;

        // First write after reset needs a turnaround; the second one from wr0 does not.
        run_seg(3'b001, 1, 8'hA5, 8'h00);
        run_seg(3'b001, 1, 8'h3C, 8'h00);

        // Everybody requesting continuously: grants rotate wr1, rd, wr0, wr1.
        run_seg(3'b111, 4, 8'($urandom), 8'($urandom));

        // ena low: no grants even with every request high.
        wait_cyc(next_dec - 1);
        bus.ena    = 1'b0;
        bus.wr_req = 2'b11;
        bus.rd_req = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("ena_off_busy", 32'(bus.busy), 32'h0);
            check("ena_off_oe", 32'(bus.uio_oe), last_out ? 32'hFF : 32'h00);
            check("ena_off_acks", {29'd0, bus.rd_ack, bus.wr_ack}, 32'h0);
        end
        @(posedge clk);
        #1;
        bus.wr_req = 2'b00;
        bus.rd_req = 1'b0;
        bus.ena    = 1'b1;
        next_dec   = cyc + 1;

        // ena drops during DRIVE: the write still completes, nothing is granted afterwards.
        start_segment(3'b011, 8'($urandom), 8'($urandom));
        do_grant(3'b011, 1'b0, dec, t, ack);
        wait_cyc(dec + t);
        bus.ena = 1'b0;
        wait_cyc(ack + 1);
        repeat (4) begin
            @(negedge clk);
            check("ena_drop_busy", 32'(bus.busy), 32'h0);
        end
        @(posedge clk);
        #1;
        bus.wr_req = 2'b00;
        bus.ena    = 1'b1;
        next_dec   = cyc + 1;

        // Reset in the first DRIVE cycle aborts the write without an ack.
        start_segment(3'b001, 8'hC3, 8'h00);
        do_grant(3'b001, 1'b1, dec, t, ack);
        wait_cyc(dec + t);
        rst = 1'b0;
        wait_cyc(dec + t + 1);
        @(negedge clk);
        check("abort_oe", 32'(bus.uio_oe), 32'h00);
        check("abort_out", 32'(bus.uio_out), 32'h00);
        check("abort_wr_ack", 32'(bus.wr_ack), 32'h0);
        check("abort_rd_data", 32'(bus.rd_data), 32'h00);
        check("abort_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        bus.wr_req = 2'b00;
        model_reset();
        next_dec   = cyc + 1;

        // Random request sets, each held for a few consecutive grants.
        repeat (40) begin
            run_seg(3'($urandom_range(1, 7)), $urandom_range(1, 4), 8'($urandom), 8'($urandom));
        end

        wait_cyc(next_dec - 1);
        bus.wr_req = 2'b00;
        bus.rd_req = 1'b0;
        wait_cyc(next_dec + 5);
        check("acks_outstanding", 32'(exp_q.size()), 32'd0);
        check("bus_states_outstanding", 32'(exp_oe.num()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uio_bus_arbiter.md
# uio_bus_arbiter

Shares the 8-bit bidirectional uio pad bus of `tt_um_top` among two write requesters and one read requester. It owns `uio_out` and `uio_oe` and samples `uio_in`. It inserts turnaround cycles on every change of bus direction and grants requesters round-robin. It sits between the internal engines and the top-level uio ports, so no other logic in the design drives `uio_oe`.

## Interface
- `TURN_CYCLES`, default 1: number of cycles (≥1) with `uio_oe`=0 inserted before a transaction whose direction differs from the previous one.
- `HOLD_CYCLES`, default 2: number of cycles (≥1) each write drives the bus.
- `clk`  in  1: sole clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `ena`  in  1: design selected. When low, no new grants are issued.
- `wr_req`  in  2: write requests; bit i belongs to requester i.
- `wr_data0`  in  8: write data of requester 0, stable while `wr_req[0]`=1.
- `wr_data1`  in  8: write data of requester 1, stable while `wr_req[1]`=1.
- `wr_ack`  out  2: one-cycle pulse marking completion of requester i's write.
- `rd_req`  in  1: read request.
- `rd_ack`  out  1: one-cycle pulse; `rd_data` is valid in this cycle.
- `rd_data`  out  8: last sampled `uio_in`; holds its value until the next read.
- `uio_in`  in  8: pad input path.
- `uio_out`  out  8: pad output path.
- `uio_oe`  out  8: pad output enable, all bits equal (0x00 or 0xFF).
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, TURN, DRIVE, SAMPLE.
- IDLE
  - `uio_oe` holds the last direction: 0xFF after a write, 0x00 after a read or reset.
  - If `ena`=1 and any request is high, grant one source by round-robin and latch the direction and the write data.
  - If the new direction ≠ `last_dir`, go to TURN. Otherwise go to DRIVE for a write or SAMPLE for a read.
- TURN
  - `uio_oe`=0x00; `uio_out` keeps its previous value.
  - Lasts TURN_CYCLES cycles, then goes to DRIVE or SAMPLE.
- DRIVE
  - `uio_oe`=0xFF; `uio_out` = latched data.
  - Lasts HOLD_CYCLES cycles.
  - `wr_ack[i]` is high during the last DRIVE cycle.
  - Then sets `last_dir`=out and goes to IDLE.
- SAMPLE
  - Lasts one cycle with `uio_oe`=0x00.
  - At the end of the cycle: `rd_data`<=`uio_in`, `rd_ack`<=1 (high in the following cycle, which is IDLE).
  - Sets `last_dir`=in and goes to IDLE.
- Round-robin
  - Sources are ordered wr0, wr1, rd.
  - Search starts at the source after the last granted one.
  - After reset the order is wr0 > wr1 > rd.
- Request handling
  - Requests are sampled only in IDLE.
  - A granted transaction always completes, even if its request drops or `ena` falls.
  - A requester must drop its req in the cycle after its ack, or it is eligible again.
- Reset
  - State: IDLE, `last_dir`=in, RR pointer at wr0.
  - Outputs: `uio_oe`=0x00, `uio_out`=0x00, `wr_ack`=0, `rd_ack`=0, `rd_data`=0x00, `busy`=0.
  - A reset mid-transaction aborts it with no ack.
  - `rst` takes precedence over all other inputs.
- `ena`=0 in IDLE holds the FSM in IDLE; `busy` stays 0.

## Timing
- Write, same direction:
  - req seen at edge E0; DRIVE occupies cycles E0..E0+HOLD_CYCLES−1.
  - Ack is in the last of those cycles; IDLE follows.
  - Latency from req to ack: HOLD_CYCLES cycles.
- Write after a read: TURN_CYCLES extra cycles come first. Default latency is 3.
- Read, same direction: SAMPLE in the cycle after E0; `rd_ack` one cycle later. Latency is 2.
- Read after a write: TURN_CYCLES extra cycles. Default latency is 3.
- Back-to-back: at least one IDLE cycle separates transactions, so default same-direction write throughput is 1 per 3 cycles.
- Simultaneous requests: exactly one grant per IDLE decision; the losers stay pending.
- `uio_oe` and `uio_out` are registered outputs with no combinational path from the inputs.

## Test plan
- Reset, then `wr_req`=01, `wr_data0`=0xA5:
  - TURN for 1 cycle with oe=0x00.
  - Then 2 cycles of oe=0xFF with `uio_out`=0xA5.
  - `wr_ack`=01 in the second DRIVE cycle; latency 3.
- After that write, a second write from wr0 with data 0x3C: no TURN, DRIVE for 2 cycles, ack at latency 2.
- `wr_req`=11 and `rd_req`=1 held continuously:
  - Grants cycle wr1, rd, wr0, wr1 (the previous grant was wr0).
  - A TURN is inserted around each rd.
  - `rd_data` equals `uio_in` as driven during SAMPLE (e.g. 0x5A).
- `ena`=0 with all requests high: `busy`=0, oe unchanged, no acks.
- Drop `ena` while in DRIVE: the write completes and acks, then no further grants.
- Assert `rst`=0 during DRIVE: on the next edge oe=0x00, `uio_out`=0x00, no ack, `busy`=0; the next write after release inserts a TURN.
